// File: rtl/ltpi_data_channel_target_mm.sv
// LTPI data-channel target: accepts request payloads and replays them as Avalon-MM accesses.
// Build option: define LTPI_DC_TARGET_WRRESP_EN to complete writes on avm_writeresponsevalid.

package ltpi_data_channel_target_mm_pkg;

    localparam int unsigned TIMER_1MS_60MHZ = 60000;

    typedef enum logic [7:0] {
        READ_REQ   = 8'h00,
        WRITE_REQ  = 8'h01,
        READ_COMP  = 8'h02,
        WRITE_COMP = 8'h03,
        CRC_ERROR  = 8'h04
    } Data_channel_cmd_t;

    typedef struct packed {
        logic [7:0]        tag;
        Data_channel_cmd_t command;
        logic [31:0]       address;
        logic [31:0]       data;
        logic [3:0]        byte_en;
        logic [3:0]        operation_status;
    } Data_channel_payload_t;

endpackage

module ltpi_data_channel_target_mm
    import ltpi_data_channel_target_mm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10 * TIMER_1MS_60MHZ
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ack,
    input  Data_channel_payload_t req,
    output logic                  resp_valid,
    output Data_channel_payload_t resp,
    output logic [31:0]           avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic [1:0]            avm_response,
    input  logic                  avm_writeresponsevalid,
    output logic                  busy,
    output logic                  timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] STATUS_OK      = 4'h0;
    localparam logic [3:0] STATUS_ERR     = 4'h1;
    localparam logic [3:0] STATUS_TIMEOUT = 4'h2;

    typedef enum logic [2:0] {
        StIdle, StAccept, StIssue, StWaitRd, StWaitWr, StResp
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_cmd_ok;
    logic                  r_is_write;
    logic [7:0]            r_tag;
    logic                  r_req_ack;
    logic                  r_resp_valid;
    logic                  r_timeout;
    Data_channel_payload_t r_resp;
    logic [31:0]           r_avm_address;
    logic                  r_avm_read;
    logic                  r_avm_write;
    logic [31:0]           r_avm_writedata;
    logic [3:0]            r_avm_byteenable;

    Data_channel_payload_t w_comp;
    logic                  w_done;
    logic                  w_expire_hit;
    logic                  w_expired;
    logic [3:0]            w_rsp_status;
    logic                  w_unused;

    function automatic logic [31:0] f_mask(input logic [31:0] data, input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? data[8*i +: 8] : 8'h00;
        return m;
    endfunction

    assign w_expired    = (r_cnt == CNT_LAST);
    assign w_rsp_status = (avm_response != 2'b00) ? STATUS_ERR : STATUS_OK;

    // Decide whether the in-flight access finishes this cycle and build its completion.
    always_comb begin
        w_done         = 1'b0;
        w_expire_hit   = 1'b0;
        w_comp         = '0;
        w_comp.tag     = r_tag;
        w_comp.command = r_is_write ? WRITE_COMP : READ_COMP;
        w_comp.address = r_avm_address;
        w_comp.byte_en = r_avm_byteenable;
        if ((r_state inside {StIssue, StWaitRd, StWaitWr}) && w_expired) begin
            w_done                  = 1'b1;
            w_expire_hit            = 1'b1;
            w_comp.operation_status = STATUS_TIMEOUT;
        end else if (!r_is_write && avm_readdatavalid &&
                     (r_state == StWaitRd || (r_state == StIssue && !avm_waitrequest))) begin
            w_done                  = 1'b1;
            w_comp.data             = f_mask(avm_readdata, r_avm_byteenable);
            w_comp.operation_status = w_rsp_status;
        end
`ifdef LTPI_DC_TARGET_WRRESP_EN
        else if (r_state == StWaitWr && avm_writeresponsevalid) begin
            w_done                  = 1'b1;
            w_comp.operation_status = w_rsp_status;
        end
`else
        else if (r_state == StIssue && r_is_write && !avm_waitrequest) begin
            w_done = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= StIdle;
            r_cnt            <= '0;
            r_cmd_ok         <= 1'b0;
            r_is_write       <= 1'b0;
            r_tag            <= '0;
            r_req_ack        <= 1'b0;
            r_resp_valid     <= 1'b0;
            r_timeout        <= 1'b0;
            r_resp           <= '0;
            r_resp.command   <= READ_REQ;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
        end else begin
            r_req_ack    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_timeout    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (req_valid) begin
                        r_tag            <= req.tag;
                        r_is_write       <= (req.command == WRITE_REQ);
                        r_cmd_ok         <= (req.command == READ_REQ) ||
                                            (req.command == WRITE_REQ);
                        r_avm_address    <= req.address;
                        r_avm_byteenable <= req.byte_en;
                        r_avm_writedata  <= f_mask(req.data, req.byte_en);
                        r_req_ack        <= 1'b1;
                        r_state          <= StAccept;
                    end
                end
                StAccept: begin
                    if (r_cmd_ok) begin
                        r_avm_read  <= !r_is_write;
                        r_avm_write <= r_is_write;
                        r_state     <= StIssue;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StIssue, StWaitRd, StWaitWr: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_avm_read   <= 1'b0;
                        r_avm_write  <= 1'b0;
                        r_resp       <= w_comp;
                        r_resp_valid <= 1'b1;
                        r_timeout    <= w_expire_hit;
                        r_state      <= StResp;
                    end else if (r_state == StIssue && !avm_waitrequest) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_state     <= r_is_write ? StWaitWr : StWaitRd;
                    end
                end
                StResp: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef LTPI_DC_TARGET_WRRESP_EN
    assign w_unused = ^req.operation_status;
`else
    assign w_unused = ^{req.operation_status, avm_writeresponsevalid};
`endif

    assign req_ack        = r_req_ack;
    assign resp_valid     = r_resp_valid;
    assign resp           = r_resp;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_byteenable;
    assign busy           = (r_state != StIdle);
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_ltpi_data_channel_target_mm.sv
// Bench for ltpi_data_channel_target_mm: vector table plus corner sequences, scoreboarded responses.
// Expectations follow LTPI_DC_TARGET_WRRESP_EN when the bench is built with it.

module tb_ltpi_data_channel_target_mm;
    import ltpi_data_channel_target_mm_pkg::*;

`ifdef LTPI_DC_TARGET_WRRESP_EN
    localparam logic WRRESP = 1'b1;
`else
    localparam logic WRRESP = 1'b0;
`endif

    logic                  clk;
    logic                  reset_n;
    logic                  req_valid;
    logic                  req_ack;
    Data_channel_payload_t req;
    logic                  resp_valid;
    Data_channel_payload_t resp;
    logic [31:0]           avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [31:0]           avm_writedata;
    logic [3:0]            avm_byteenable;
    logic                  avm_waitrequest;
    logic [31:0]           avm_readdata;
    logic                  avm_readdatavalid;
    logic [1:0]            avm_response;
    logic                  avm_writeresponsevalid;
    logic                  busy;
    logic                  timeout;

    typedef struct {
        Data_channel_cmd_t cmd;
        logic [7:0]        tag;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        int unsigned       wait_cyc;
        int unsigned       lat;
        logic [31:0]       rdata;
        logic [1:0]        rsp;
        logic [31:0]       exp_wdata;
        logic [31:0]       exp_data;
        logic [3:0]        exp_status;
    } vec_t;

    Data_channel_payload_t sb[$];
    vec_t                  vecs[7];
    int                    n_checks;
    int                    n_pass;
    int                    n_resp;

    ltpi_data_channel_target_mm #(
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .req_valid             (req_valid),
        .req_ack               (req_ack),
        .req                   (req),
        .resp_valid            (resp_valid),
        .resp                  (resp),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_write             (avm_write),
        .avm_writedata         (avm_writedata),
        .avm_byteenable        (avm_byteenable),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid),
        .avm_response          (avm_response),
        .avm_writeresponsevalid(avm_writeresponsevalid),
        .busy                  (busy),
        .timeout               (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input Data_channel_cmd_t cmd, input logic [7:0] tag,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int unsigned wait_cyc,
                                input int unsigned lat, input logic [31:0] rdata,
                                input logic [1:0] rsp, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_data, input logic [3:0] exp_status);
        vec_t v;
        v.cmd = cmd; v.tag = tag; v.addr = addr; v.wdata = wdata; v.be = be;
        v.wait_cyc = wait_cyc; v.lat = lat; v.rdata = rdata; v.rsp = rsp;
        v.exp_wdata = exp_wdata; v.exp_data = exp_data; v.exp_status = exp_status;
        return v;
    endfunction

    function automatic Data_channel_payload_t exp_payload(input vec_t v);
        Data_channel_payload_t p;
        p.tag              = v.tag;
        p.command          = (v.cmd == WRITE_REQ) ? WRITE_COMP : READ_COMP;
        p.address          = v.addr;
        p.data             = v.exp_data;
        p.byte_en          = v.be;
        p.operation_status = v.exp_status;
        return p;
    endfunction

    // Scoreboard: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            check("resp_vs_ack", req_ack, 1'b0);
            if (sb.size() == 0) begin
                check("resp_unexpected", resp_valid, 1'b0);
            end else begin
                check("resp_payload", resp, sb.pop_front());
            end
        end
    end

    task automatic present(input vec_t v);
        req_valid            = 1'b1;
        req.tag              = v.tag;
        req.command          = v.cmd;
        req.address          = v.addr;
        req.data             = v.wdata;
        req.byte_en          = v.be;
        req.operation_status = 4'h0;
    endtask

    task automatic wait_ack(input vec_t v);
        int n = 0;
        while (!req_ack && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_seen", req_ack, 1'b1);
        req_valid = 1'b0;
        if (v.cmd == READ_REQ || v.cmd == WRITE_REQ) sb.push_back(exp_payload(v));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("return_idle", busy, 1'b0);
        check("resp_outstanding", sb.size(), 0);
    endtask

    task automatic drive_local(input vec_t v);
        logic is_wr;
        is_wr = (v.cmd == WRITE_REQ);
        avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        check("ack_one_cycle", req_ack, 1'b0);
        check("issue_bus", {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata},
              {!is_wr, is_wr, v.addr, v.be, v.exp_wdata});
        for (int i = 0; i < int'(v.wait_cyc); i++) begin
            @(posedge clk); #1;
        end
        check("hold_bus", {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata},
              {!is_wr, is_wr, v.addr, v.be, v.exp_wdata});
        avm_waitrequest = 1'b0;
        avm_response    = v.rsp;
        if (!is_wr && v.lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = v.rdata;
        end
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        avm_response      = 2'b00;
        check("strobe_drop", {avm_read, avm_write}, 2'b00);
        if (v.lat > 0 && (!is_wr || WRRESP)) begin
            for (int i = 1; i < int'(v.lat); i++) begin
                @(posedge clk); #1;
            end
            if (is_wr) avm_writeresponsevalid = 1'b1;
            else avm_readdatavalid = 1'b1;
            avm_readdata = is_wr ? 32'hFFFF_FFFF : v.rdata;
            avm_response = v.rsp;
            @(posedge clk); #1;
            avm_readdatavalid      = 1'b0;
            avm_writeresponsevalid = 1'b0;
            avm_readdata           = '0;
            avm_response           = 2'b00;
        end
        wait_idle();
    endtask

    initial begin
        vec_t v_crc, v_to, v_a, v_b, v_r1, v_r2;
        int   base;
        n_checks = 0; n_pass = 0; n_resp = 0;
        reset_n = 1'b0; req_valid = 1'b0; req = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        avm_response = 2'b00; avm_writeresponsevalid = 1'b0;

        //          cmd        tag    addr        wdata         be    wt lat rdata        rsp
        //          exp_wdata     exp_data      exp_status
        vecs[0] = mk(READ_REQ,  8'h05, 32'h100,  32'h0,        4'h3, 3, 1, 32'hAABBCCDD, 2'd0,
                     32'h0,        32'h0000CCDD, 4'h0);
        vecs[1] = mk(WRITE_REQ, 8'h06, 32'h20,   32'h12345678, 4'h8, 0, 1, 32'h0,        2'd2,
                     32'h12000000, 32'h0,        WRRESP ? 4'h1 : 4'h0);
        vecs[2] = mk(READ_REQ,  8'h07, 32'h44,   32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 2'd0,
                     32'h0,        32'hDEADBEEF, 4'h0);
        vecs[3] = mk(READ_REQ,  8'h08, 32'h48,   32'h55,       4'h5, 1, 2, 32'h11223344, 2'd3,
                     32'h55,       32'h00220044, 4'h1);
        vecs[4] = mk(WRITE_REQ, 8'h09, 32'h1000, 32'hA5A55A5A, 4'hF, 2, 2, 32'h0,        2'd0,
                     32'hA5A55A5A, 32'h0,        4'h0);
        vecs[5] = mk(WRITE_REQ, 8'h0C, 32'h2000, 32'hFFFFFFFF, 4'h6, 1, 1, 32'h0,        2'd1,
                     32'h00FFFF00, 32'h0,        WRRESP ? 4'h1 : 4'h0);
        vecs[6] = mk(READ_REQ,  8'h0D, 32'h3000, 32'h0,        4'h0, 0, 3, 32'hFFFFFFFF, 2'd0,
                     32'h0,        32'h0,        4'h0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {req_ack, resp_valid, resp, avm_address, avm_read, avm_write,
                                avm_writedata, avm_byteenable, busy, timeout}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            present(vecs[i]);
            wait_ack(vecs[i]);
            drive_local(vecs[i]);
        end

        // Unknown command is acked and dropped.
        v_crc = mk(CRC_ERROR, 8'h0A, 32'h300, 32'h0, 4'hF, 0, 0, 32'h0, 2'd0, 32'h0, 32'h0, 4'h0);
        present(v_crc);
        wait_ack(v_crc);
        check("crc_no_strobe", {avm_read, avm_write}, 2'b00);
        @(posedge clk); #1;
        check("crc_dropped", {req_ack, avm_read, avm_write, busy}, 4'b0000);
        wait_idle();

        // Local timeout with waitrequest stuck high.
        v_to = mk(READ_REQ, 8'h0B, 32'h200, 32'h0, 4'hF, 0, 0, 32'h0, 2'd0, 32'h0, 32'h0, 4'h2);
        present(v_to);
        wait_ack(v_to);
        avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 15) check("timeout_early", {timeout, avm_read}, 2'b01);
        end
        check("timeout_pulse", {timeout, resp_valid, avm_read, avm_write}, 4'b1100);
        @(posedge clk); #1;
        check("timeout_one_cycle", timeout, 1'b0);
        avm_waitrequest = 1'b0;
        wait_idle();

        // Back-to-back: second request held while the first is in flight.
        v_a = mk(READ_REQ, 8'h21, 32'h400, 32'h0, 4'hF, 2, 2, 32'h01020304, 2'd0,
                 32'h0, 32'h01020304, 4'h0);
        v_b = mk(WRITE_REQ, 8'h22, 32'h404, 32'hCAFEF00D, 4'hF, 1, 1, 32'h0, 2'd0,
                 32'hCAFEF00D, 32'h0, 4'h0);
        present(v_a);
        wait_ack(v_a);
        base = n_resp;
        present(v_b);
        drive_local(v_a);
        wait_ack(v_b);
        check("b2b_ack_after_resp", n_resp - base, 1);
        drive_local(v_b);

        // Reset while waiting for read data.
        v_r1 = mk(READ_REQ, 8'h31, 32'h500, 32'h0, 4'hF, 0, 3, 32'h0, 2'd0, 32'h0, 32'h0, 4'h0);
        present(v_r1);
        wait_ack(v_r1);
        avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        check("in_wait_rd", {busy, avm_read}, 2'b10);
        sb.delete();
        base    = n_resp;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_outputs", {req_ack, resp_valid, resp, avm_address, avm_read,
                                    avm_write, avm_writedata, avm_byteenable, busy, timeout}, '0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h99999999;
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        reset_n           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_resp", n_resp - base, 0);
        v_r2 = mk(READ_REQ, 8'h32, 32'h504, 32'h0, 4'h3, 1, 1, 32'h87654321, 2'd0,
                  32'h0, 32'h00004321, 4'h0);
        present(v_r2);
        wait_ack(v_r2);
        drive_local(v_r2);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
